// File: rtl/mcpu_ctrl_if.sv
// rtl/mcpu_ctrl_if.sv - opcode/handshake and datapath control bundle for mcpu_ctrl
interface mcpu_ctrl_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );
endinterface

// File: rtl/mcpu_ctrl.sv
// rtl/mcpu_ctrl.sv - multicycle MIPS-subset control FSM
module mcpu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  mcpu_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_RST = 4'd0,  S_IF  = 4'd1,  S_ID  = 4'd2,  S_MA  = 4'd3,
    S_MR  = 4'd4,  S_MW  = 4'd5,  S_WBM = 4'd6,  S_EXR = 4'd7,
    S_WBR = 4'd8,  S_BEQ = 4'd9,  S_J   = 4'd10, S_EXI = 4'd11,
    S_WBI = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic       w_illegal_id;
  logic       w_pc_write, w_pc_write_cond, w_iord, w_mem_read, w_mem_write;
  logic       w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
  logic [1:0] w_alu_src_b, w_alu_op, w_pc_source;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RST;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_illegal_id) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next          = S_IF;
    w_illegal_id    = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 2'b00;
    w_pc_source     = 2'b00;
    case (r_state)
      S_RST: w_next = S_IF;
      S_IF: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = bus.mem_ready;
        w_pc_write  = bus.mem_ready;
        w_next      = bus.mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        // Branch target is precomputed into ALUOut regardless of opcode.
        w_alu_src_b = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MA;
          OP_R:         w_next = S_EXR;
          OP_BEQ:       w_next = S_BEQ;
          OP_J:         w_next = S_J;
          OP_ADDI:      w_next = S_EXI;
          default: begin
            w_illegal_id = 1'b1;
            w_next       = S_IF;
          end
        endcase
      end
      S_MA: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        if (bus.op == OP_LW)      w_next = S_MR;
        else if (bus.op == OP_SW) w_next = S_MW;
        else                      w_next = S_IF;
      end
      S_MR: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        w_next     = bus.mem_ready ? S_WBM : S_MR;
      end
      S_MW: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        w_next      = bus.mem_ready ? S_IF : S_MW;
      end
      S_WBM: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_EXR: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
        w_next      = S_WBR;
      end
      S_WBR: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_BEQ: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = 2'b01;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
      end
      S_J: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b10;
      end
      S_EXI: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = S_WBI;
      end
      S_WBI: w_reg_write = 1'b1;
      default: w_next = S_IF;
    endcase
  end

  assign bus.pc_write      = w_pc_write;
  assign bus.pc_write_cond = w_pc_write_cond;
  assign bus.iord          = w_iord;
  assign bus.mem_read      = w_mem_read;
  assign bus.mem_write     = w_mem_write;
  assign bus.ir_write      = w_ir_write;
  assign bus.mem_to_reg    = w_mem_to_reg;
  assign bus.reg_dst       = w_reg_dst;
  assign bus.reg_write     = w_reg_write;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.alu_op        = w_alu_op;
  assign bus.pc_source     = w_pc_source;
  // The flag is visible in the very ID cycle that decodes the bad opcode.
  assign bus.illegal_op    = r_illegal | w_illegal_id;
  assign bus.state         = r_state;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb/tb_mcpu_ctrl.sv - scoreboard testbench for mcpu_ctrl
module tb_mcpu_ctrl;
  localparam logic [3:0] RST = 4'd0, IFS = 4'd1, ID = 4'd2, MA = 4'd3, MR = 4'd4,
                         MW = 4'd5, WBM = 4'd6, EXR = 4'd7, WBR = 4'd8, BEQ = 4'd9,
                         JS = 4'd10, EXI = 4'd11, WBI = 4'd12;
  localparam logic [5:0] OR = 6'b000000, OLW = 6'b100011, OSW = 6'b101011,
                         OBQ = 6'b000100, OJ = 6'b000010, OAI = 6'b001000,
                         OBAD = 6'b111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;
  int   n_cyc = 0;
  logic [20:0] exp_q[$];

  mcpu_ctrl_if bus();
  mcpu_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Bit order: pc_write pc_write_cond iord mem_read mem_write ir_write
  //            mem_to_reg reg_dst reg_write alu_src_a alu_src_b alu_op pc_source
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr);
    case (st)
      IFS:     return {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 4'b0000, 2'b01, 2'b00, 2'b00};
      ID:      return 16'b0000_0000_0011_0000;
      MA:      return 16'b0000_0000_0110_0000;
      MR:      return 16'b0011_0000_0000_0000;
      MW:      return 16'b0010_1000_0000_0000;
      WBM:     return 16'b0000_0010_1000_0000;
      EXR:     return 16'b0000_0000_0100_1000;
      WBR:     return 16'b0000_0001_1000_0000;
      BEQ:     return 16'b0100_0000_0100_0101;
      JS:      return 16'b1000_0000_0000_0010;
      EXI:     return 16'b0000_0000_0110_0000;
      WBI:     return 16'b0000_0000_1000_0000;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] got_ctrl();
    return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask

  // One stimulus cycle: drive inputs after the edge and queue the expected response.
  task automatic cyc(input logic [5:0] op, input logic mr, input logic [3:0] st, input logic ill);
    @(posedge clk);
    #1;
    bus.op = op;
    bus.mem_ready = mr;
    exp_q.push_back({st, ill, exp_ctrl(st, mr)});
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back({RST, 1'b0, 16'h0000});
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [20:0] e;
      logic [20:0] g;
      e = exp_q.pop_front();
      g = {bus.state, bus.illegal_op, got_ctrl()};
      n_cyc++;
      n_total++;
      if (g === e) n_pass++;
      else $display("FAIL cycle%0d: got st=%0d ill=%b ctrl=%h, want st=%0d ill=%b ctrl=%h",
                    n_cyc, g[20:17], g[16], g[15:0], e[20:17], e[16], e[15:0]);
    end
  end

  initial begin
    bus.op = OR;
    bus.mem_ready = 1'b0;
    cyc(OR, 1'b0, RST, 1'b0);
    cyc(OR, 1'b1, RST, 1'b0);
    release_rst();
    // fetch wait, then R-type
    cyc(OR, 1'b0, IFS, 1'b0);
    cyc(OR, 1'b0, IFS, 1'b0);
    cyc(OR, 1'b0, IFS, 1'b0);
    cyc(OR, 1'b1, IFS, 1'b0);
    cyc(OR, 1'b1, ID, 1'b0);
    cyc(OR, 1'b1, EXR, 1'b0);
    cyc(OR, 1'b1, WBR, 1'b0);
    // lw, sw, beq, j, addi with zero wait
    cyc(OLW, 1'b1, IFS, 1'b0); cyc(OLW, 1'b1, ID, 1'b0); cyc(OLW, 1'b1, MA, 1'b0);
    cyc(OLW, 1'b1, MR, 1'b0);  cyc(OLW, 1'b1, WBM, 1'b0);
    cyc(OSW, 1'b1, IFS, 1'b0); cyc(OSW, 1'b1, ID, 1'b0); cyc(OSW, 1'b1, MA, 1'b0);
    cyc(OSW, 1'b1, MW, 1'b0);
    cyc(OBQ, 1'b1, IFS, 1'b0); cyc(OBQ, 1'b1, ID, 1'b0); cyc(OBQ, 1'b1, BEQ, 1'b0);
    cyc(OJ, 1'b1, IFS, 1'b0);  cyc(OJ, 1'b1, ID, 1'b0);  cyc(OJ, 1'b1, JS, 1'b0);
    cyc(OAI, 1'b1, IFS, 1'b0); cyc(OAI, 1'b1, ID, 1'b0); cyc(OAI, 1'b1, EXI, 1'b0);
    cyc(OAI, 1'b1, WBI, 1'b0);
    // lw with two wait cycles in MR
    cyc(OLW, 1'b1, IFS, 1'b0); cyc(OLW, 1'b1, ID, 1'b0); cyc(OLW, 1'b1, MA, 1'b0);
    cyc(OLW, 1'b0, MR, 1'b0);  cyc(OLW, 1'b0, MR, 1'b0); cyc(OLW, 1'b1, MR, 1'b0);
    cyc(OLW, 1'b1, WBM, 1'b0);
    // sw stalled in MW, then asynchronous reset mid-cycle
    cyc(OSW, 1'b1, IFS, 1'b0); cyc(OSW, 1'b1, ID, 1'b0); cyc(OSW, 1'b1, MA, 1'b0);
    cyc(OSW, 1'b0, MW, 1'b0);  cyc(OSW, 1'b0, MW, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("rst_state", {28'd0, bus.state}, {28'd0, RST});
    chk("rst_ctrl", {16'd0, got_ctrl()}, 32'd0);
    release_rst();
    // illegal opcode is sticky through a following R-type
    cyc(OBAD, 1'b1, IFS, 1'b0);
    cyc(OBAD, 1'b1, ID, 1'b1);
    cyc(OR, 1'b1, IFS, 1'b1);
    cyc(OR, 1'b1, ID, 1'b1);
    cyc(OR, 1'b1, EXR, 1'b1);
    cyc(OR, 1'b1, WBR, 1'b1);
    cyc(OR, 1'b1, IFS, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_illegal", {31'd0, bus.illegal_op}, 32'd0);
    chk("rst_state2", {28'd0, bus.state}, {28'd0, RST});
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
